// File: rtl/mem_router_pkg.sv
// Shared types and constants for the memory request router.
// The stats counter width applies only when MEM_REQ_ROUTER_STATS_EN is defined.
package mem_router_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } buf_state_e;

    localparam int unsigned TGT_D  = 0;
    localparam int unsigned TGT_I  = 1;
    localparam int unsigned STAT_W = 16;

endpackage

// File: rtl/mem_req_router_if.sv
// Core-side request stream and per-target memory-side ports of the router.
// master drives requests and downstream ready; slave is the router.
interface mem_req_router_if #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned N_TARGETS = 2,
    parameter int unsigned SEL_W     = 3
);
    logic                          in_valid;
    logic                          in_ready;
    logic [DATA_W-1:0]             in_data;
    logic [SEL_W-1:0]              in_sel;
    logic [N_TARGETS-1:0]          out_valid;
    logic [N_TARGETS-1:0]          out_ready;
    logic [N_TARGETS*DATA_W-1:0]   out_data;

    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/router_skid_buf.sv
// Two-entry in-order skid buffer with registered push_ready and head_valid.
// The head entry always sits in head_q; tail_q holds the second entry when full.
module router_skid_buf
    import mem_router_pkg::*;
#(
    parameter int unsigned W = 35
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_valid,
    output logic         push_ready,
    input  logic [W-1:0] push_data,
    output logic         head_valid,
    output logic [W-1:0] head_data,
    input  logic         pop
);

    buf_state_e   state_q, state_d;
    logic [W-1:0] head_q, head_d;
    logic [W-1:0] tail_q, tail_d;
    logic         push;

    assign push      = push_valid & push_ready;
    assign head_data = head_q;

    // Next state and entry updates; pop is only meaningful while non-empty.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d = ONE;
                    head_d  = push_data;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_d = push_data;
                end else if (push) begin
                    state_d = TWO;
                    tail_d  = push_data;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    state_d = ONE;
                    head_d  = tail_q;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            head_q     <= '0;
            tail_q     <= '0;
            push_ready <= 1'b1;
            head_valid <= 1'b0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            push_ready <= (state_d != TWO);
            head_valid <= (state_d != EMPTY);
        end
    end

endmodule

// File: rtl/mem_req_router.sv
// Routes one core request stream to N_TARGETS ports via a 2-entry skid buffer,
// discarding out-of-range selectors. Define MEM_REQ_ROUTER_STATS_EN for counters.
module mem_req_router
    import mem_router_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned N_TARGETS = 2,
    parameter int unsigned SEL_W     = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
`ifdef MEM_REQ_ROUTER_STATS_EN
    input  logic                        stat_clr,
    output logic [N_TARGETS*STAT_W-1:0] stat_cnt,
    output logic [STAT_W-1:0]           stat_err,
`endif
    mem_req_router_if.slave             bus,
    output logic                        err_pulse,
    output logic [SEL_W-1:0]            err_sel
);

    localparam int unsigned ENTRY_W = SEL_W + DATA_W;

    generate
        if (N_TARGETS < 2 || N_TARGETS > 8 || (2 ** SEL_W) < N_TARGETS) begin : g_bad_cfg
            $error("mem_req_router: illegal N_TARGETS/SEL_W combination");
        end
    endgenerate

    logic [ENTRY_W-1:0]   head;
    logic                 head_valid;
    logic [SEL_W-1:0]     head_sel;
    logic [DATA_W-1:0]    head_data;
    logic                 sel_ok;
    logic                 route;
    logic                 discard;
    logic                 pop;
    logic [N_TARGETS-1:0] hs;
    logic [SEL_W-1:0]     err_sel_q;

    router_skid_buf #(
        .W (ENTRY_W)
    ) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (bus.in_valid),
        .push_ready (bus.in_ready),
        .push_data  ({bus.in_sel, bus.in_data}),
        .head_valid (head_valid),
        .head_data  (head),
        .pop        (pop)
    );

    assign head_sel  = head[ENTRY_W-1 -: SEL_W];
    assign head_data = head[DATA_W-1:0];
    assign sel_ok    = (32'(head_sel) < N_TARGETS);
    assign route     = enable & head_valid & sel_ok;
    assign discard   = enable & head_valid & ~sel_ok;

    // Present the head on exactly its selected port; everything else stays zero.
    always_comb begin
        bus.out_valid = '0;
        bus.out_data  = '0;
        for (int unsigned k = 0; k < N_TARGETS; k++) begin
            if (route && head_sel == SEL_W'(k)) begin
                bus.out_valid[k]                  = 1'b1;
                bus.out_data[k*DATA_W +: DATA_W]  = head_data;
            end
        end
    end

    // out_ready on an idle port is masked by out_valid.
    assign hs  = bus.out_valid & bus.out_ready;
    assign pop = (|hs) | discard;

    // err_sel shows the discarded selector in the discard cycle, then holds it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sel_q <= '0;
        end else if (discard) begin
            err_sel_q <= head_sel;
        end
    end

    assign err_pulse = discard;
    assign err_sel   = discard ? head_sel : err_sel_q;

`ifdef MEM_REQ_ROUTER_STATS_EN
    logic [STAT_W-1:0] cnt_q [N_TARGETS];
    logic [STAT_W-1:0] err_cnt_q;

    // Saturating counters; clear takes priority over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < N_TARGETS; k++) begin
                cnt_q[k] <= '0;
            end
            err_cnt_q <= '0;
        end else if (stat_clr) begin
            for (int unsigned k = 0; k < N_TARGETS; k++) begin
                cnt_q[k] <= '0;
            end
            err_cnt_q <= '0;
        end else begin
            for (int unsigned k = 0; k < N_TARGETS; k++) begin
                if (hs[k] && cnt_q[k] != '1) begin
                    cnt_q[k] <= cnt_q[k] + STAT_W'(1);
                end
            end
            if (discard && err_cnt_q != '1) begin
                err_cnt_q <= err_cnt_q + STAT_W'(1);
            end
        end
    end

    generate
        for (genvar g = 0; g < int'(N_TARGETS); g++) begin : g_stat
            assign stat_cnt[g*STAT_W +: STAT_W] = cnt_q[g];
        end
    endgenerate

    assign stat_err = err_cnt_q;
`endif

endmodule

// File: tb/tb_mem_req_router.sv
// Scoreboard bench for mem_req_router with N_TARGETS=3: stimulus pushes expected
// deliveries/discards, a negedge monitor pops and compares them in order.
module tb_mem_req_router;
    import mem_router_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned NT = 3;
    localparam int unsigned SW = 3;

    typedef struct {
        bit          is_err;
        int unsigned port;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          err_pulse;
    logic [SW-1:0] err_sel;
`ifdef MEM_REQ_ROUTER_STATS_EN
    logic                   stat_clr = 1'b0;
    logic [NT*STAT_W-1:0]   stat_cnt;
    logic [STAT_W-1:0]      stat_err;
`endif

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   n_hs = 0;

    always #5 clk = ~clk;

    mem_req_router_if #(.DATA_W(DW), .N_TARGETS(NT), .SEL_W(SW)) bus ();

    mem_req_router #(.DATA_W(DW), .N_TARGETS(NT), .SEL_W(SW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
`ifdef MEM_REQ_ROUTER_STATS_EN
        .stat_clr  (stat_clr),
        .stat_cnt  (stat_cnt),
        .stat_err  (stat_err),
`endif
        .bus       (bus),
        .err_pulse (err_pulse),
        .err_sel   (err_sel)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Issue one request and hold it until accepted; called just after a posedge.
    task automatic send(input logic [SW-1:0] sel, input logic [DW-1:0] data);
        exp_t e;
        logic rdy;
        int   n;
        n = 0;
        e.is_err = (sel >= SW'(NT));
        e.port   = 32'(sel);
        e.data   = data;
        q.push_back(e);
        bus.in_valid = 1'b1;
        bus.in_sel   = sel;
        bus.in_data  = data;
        do begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
            n++;
        end while (!rdy && n < 50);
        check("send_timeout", 64'(rdy), 64'(1));
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every discard and every handshake must match the next expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (bus.out_valid != '0 || err_pulse) begin
                check("onehot0", 64'($onehot0(bus.out_valid)), 64'(1));
                for (int k = 0; k < int'(NT); k++) begin
                    if (!bus.out_valid[k])
                        check("idle_slice", 64'(bus.out_data[k*DW +: DW]), 64'(0));
                end
            end
            if (err_pulse) begin
                if (q.size() == 0) begin
                    check("err_unexpected", 64'(q.size()), 64'(1));
                end else begin
                    e = q.pop_front();
                    check("err_kind", 64'(e.is_err), 64'(1));
                    check("err_sel", 64'(err_sel), 64'(e.port));
                    check("err_no_valid", 64'(bus.out_valid), 64'(0));
                end
            end
            for (int k = 0; k < int'(NT); k++) begin
                if (bus.out_valid[k] && bus.out_ready[k]) begin
                    n_hs++;
                    if (q.size() == 0) begin
                        check("hs_unexpected", 64'(q.size()), 64'(1));
                    end else begin
                        e = q.pop_front();
                        check("hs_kind", 64'(e.is_err), 64'(0));
                        check("hs_port", 64'(k), 64'(e.port));
                        check("hs_data", 64'(bus.out_data[k*DW +: DW]), 64'(e.data));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int exp_hs;
        exp_hs = 7;
`ifdef MEM_REQ_ROUTER_STATS_EN
        exp_hs = 12;
`endif
        bus.in_valid  = 1'b0;
        bus.in_sel    = '0;
        bus.in_data   = '0;
        bus.out_ready = '0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'(1));
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_out_data", 64'(bus.out_data), 64'(0));
        check("rst_err_pulse", 64'(err_pulse), 64'(0));
        check("rst_err_sel", 64'(err_sel), 64'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(1);

        // Back-to-back routing to D then port 2
        enable = 1'b1;
        bus.out_ready = '1;
        begin
            exp_t e;
            e.is_err = 1'b0; e.port = TGT_D; e.data = 32'hA5A5_0001;
            q.push_back(e);
            bus.in_valid = 1'b1; bus.in_sel = 3'd0; bus.in_data = 32'hA5A5_0001;
            @(negedge clk);
            check("t2_rdy", 64'(bus.in_ready), 64'(1));
            @(posedge clk);
            #1;
            e.port = 2; e.data = 32'h0000_BEEF;
            q.push_back(e);
            bus.in_sel = 3'd2; bus.in_data = 32'h0000_BEEF;
            @(negedge clk);
            check("t2_ov_a", 64'(bus.out_valid), 64'(3'b001));
            check("t2_data_a", 64'(bus.out_data[0 +: DW]), 64'(32'hA5A5_0001));
            check("t2_rdy2", 64'(bus.in_ready), 64'(1));
            @(posedge clk);
            #1 bus.in_valid = 1'b0;
            @(negedge clk);
            check("t2_ov_b", 64'(bus.out_valid), 64'(3'b100));
            check("t2_data_b", 64'(bus.out_data[2*DW +: DW]), 64'(32'h0000_BEEF));
            @(posedge clk);
            #1;
        end

        // Backpressure on port 1
        bus.out_ready = 3'b101;
        send(3'd1, 32'h1111_0001);
        send(3'd1, 32'h1111_0002);
        @(negedge clk);
        check("t3_full", 64'(bus.in_ready), 64'(0));
        check("t3_ov", 64'(bus.out_valid), 64'(3'b010));
        check("t3_head", 64'(bus.out_data[DW +: DW]), 64'(32'h1111_0001));
        @(posedge clk);
        #1;
        fork
            send(3'd1, 32'h1111_0003);
            begin
                repeat (3) begin
                    @(negedge clk);
                    check("t3_held", 64'(bus.in_ready), 64'(0));
                end
                @(posedge clk);
                #1 bus.out_ready = 3'b111;
            end
        join
        cyc(4);
        check("t3_drained", 64'(q.size()), 64'(0));

        // Out-of-range selector followed by a valid one
        send(3'd5, 32'h0000_0055);
        send(3'd0, 32'h00C0_FFEE);
        @(negedge clk);
        check("t4_pulse_once", 64'(err_pulse), 64'(0));
        check("t4_err_hold", 64'(err_sel), 64'(5));
        check("t4_next_ov", 64'(bus.out_valid), 64'(3'b001));
        @(posedge clk);
        #1;

        // Disabled routing holds the head
        enable = 1'b0;
        send(3'd1, 32'h000D_00D1);
        repeat (4) begin
            @(negedge clk);
            check("t5_ov_off", 64'(bus.out_valid), 64'(0));
            check("t5_od_off", 64'(bus.out_data), 64'(0));
            check("t5_rdy", 64'(bus.in_ready), 64'(1));
            check("t5_no_err", 64'(err_pulse), 64'(0));
        end
        @(posedge clk);
        #1 enable = 1'b1;
        @(negedge clk);
        check("t5_resume_ov", 64'(bus.out_valid), 64'(3'b010));
        check("t5_resume_d", 64'(bus.out_data[DW +: DW]), 64'(32'h000D_00D1));
        @(posedge clk);
        #1;

        // Reset with two entries buffered
        bus.out_ready = '0;
        send(3'd0, 32'hE000_0001);
        send(3'd2, 32'hE000_0002);
        @(negedge clk);
        check("t1_full", 64'(bus.in_ready), 64'(0));
        check("t1_ov", 64'(bus.out_valid), 64'(3'b001));
        #2 rst_n = 1'b0;
        q.delete();
        #1;
        check("t1_rst_ov", 64'(bus.out_valid), 64'(0));
        check("t1_rst_od", 64'(bus.out_data), 64'(0));
        check("t1_rst_rdy", 64'(bus.in_ready), 64'(1));
        check("t1_rst_esel", 64'(err_sel), 64'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.out_ready = '1;
        @(negedge clk);
        check("t1_lost_ov", 64'(bus.out_valid), 64'(0));
        check("t1_post_rdy", 64'(bus.in_ready), 64'(1));
        @(posedge clk);
        #1;

`ifdef MEM_REQ_ROUTER_STATS_EN
        for (int i = 0; i < 5; i++) send(3'd0, 32'h5000_0000 + 32'(i));
        send(3'd6, 32'h0000_0006);
        send(3'd7, 32'h0000_0007);
        cyc(4);
        check("st_port0", 64'(stat_cnt[0 +: STAT_W]), 64'(5));
        check("st_port1", 64'(stat_cnt[STAT_W +: STAT_W]), 64'(0));
        check("st_err", 64'(stat_err), 64'(2));
        stat_clr = 1'b1;
        @(posedge clk);
        #1 stat_clr = 1'b0;
        @(negedge clk);
        check("st_clr_cnt", 64'(stat_cnt), 64'(0));
        check("st_clr_err", 64'(stat_err), 64'(0));
        @(posedge clk);
        #1;
`endif

        cyc(3);
        check("final_q_empty", 64'(q.size()), 64'(0));
        check("hs_count", 64'(n_hs), 64'(exp_hs));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
